// File: rtl/midi_note_decoder_if.sv
// Byte-in / note-out bus of the MIDI note decoder.
// note layout: {on, note[6:0], velocity[6:0]}; on=1 means NOTE ON, on=0 means NOTE OFF.
interface midi_note_decoder_if;
    logic [7:0]  midi_byte;
    logic        midi_byte_ready;
    logic [14:0] note;
    logic        note_ready;

    modport master (
        output midi_byte,
        output midi_byte_ready,
        input  note,
        input  note_ready
    );

    modport slave (
        input  midi_byte,
        input  midi_byte_ready,
        output note,
        output note_ready
    );
endinterface

// File: rtl/midi_note_decoder.sv
// MIDI byte stream to note on/off decoder; optional running status via MIDI_RUNNING_STATUS_EN.
// Non-note channel messages are skipped by length; SysEx is swallowed; real-time bytes are ignored.
module midi_note_decoder #(
    parameter logic [3:0] CHANNEL = 4'd0,
    parameter bit         OMNI    = 1'b0
) (
    input  logic                 clock_50_000_000,
    input  logic                 reset_l,
    midi_note_decoder_if.slave   bus
);

    typedef enum logic [1:0] {StIdle, StData1, StData2, StSkip} state_e;

    state_e      state_q, state_d;
    logic        kind_q, kind_d;
    logic [6:0]  note_num_q, note_num_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [1:0]  skip_len_q, skip_len_d;
    logic [14:0] note_q, note_d;
    logic        note_ready_q, note_ready_d;

    logic [3:0]  hi_nib;
    logic        chan_ok;
    logic [6:0]  vel;

    assign hi_nib  = bus.midi_byte[7:4];
    assign chan_ok = OMNI || (bus.midi_byte[3:0] == CHANNEL);
    assign vel     = bus.midi_byte[6:0];

    always_comb begin
        state_d      = state_q;
        kind_d       = kind_q;
        note_num_d   = note_num_q;
        cnt_d        = cnt_q;
        skip_len_d   = skip_len_q;
        note_d       = note_q;
        note_ready_d = 1'b0;

        if (bus.midi_byte_ready) begin
            if (bus.midi_byte[7]) begin
                case (hi_nib)
                    4'h8, 4'h9: begin
                        if (chan_ok) begin
                            kind_d  = (hi_nib == 4'h9);
                            state_d = StData1;
                        end else begin
                            state_d    = StSkip;
                            cnt_d      = 2'd2;
                            skip_len_d = 2'd2;
                        end
                    end
                    4'hA, 4'hB, 4'hE: begin
                        state_d    = StSkip;
                        cnt_d      = 2'd2;
                        skip_len_d = 2'd2;
                    end
                    4'hC, 4'hD: begin
                        state_d    = StSkip;
                        cnt_d      = 2'd1;
                        skip_len_d = 2'd1;
                    end
                    default: begin
                        // 0xF8-0xFF are real-time and leave everything untouched.
                        if (!bus.midi_byte[3]) begin
                            state_d    = StIdle;
                            cnt_d      = 2'd0;
                            skip_len_d = 2'd0;
                        end
                    end
                endcase
            end else begin
                case (state_q)
                    StData1: begin
                        note_num_d = bus.midi_byte[6:0];
                        state_d    = StData2;
                    end
                    StData2: begin
                        // NOTE ON with velocity 0 is reported as NOTE OFF.
                        note_d       = {kind_q && (vel != 7'd0), note_num_q, vel};
                        note_ready_d = 1'b1;
`ifdef MIDI_RUNNING_STATUS_EN
                        state_d      = StData1;
`else
                        state_d      = StIdle;
`endif
                    end
                    StSkip: begin
                        if (cnt_q <= 2'd1) begin
`ifdef MIDI_RUNNING_STATUS_EN
                            cnt_d   = skip_len_q;
`else
                            cnt_d   = 2'd0;
                            state_d = StIdle;
`endif
                        end else begin
                            cnt_d = cnt_q - 2'd1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clock_50_000_000 or negedge reset_l) begin
        if (!reset_l) begin
            state_q      <= StIdle;
            kind_q       <= 1'b0;
            note_num_q   <= 7'd0;
            cnt_q        <= 2'd0;
            skip_len_q   <= 2'd0;
            note_q       <= 15'd0;
            note_ready_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            kind_q       <= kind_d;
            note_num_q   <= note_num_d;
            cnt_q        <= cnt_d;
            skip_len_q   <= skip_len_d;
            note_q       <= note_d;
            note_ready_q <= note_ready_d;
        end
    end

    assign bus.note       = note_q;
    assign bus.note_ready = note_ready_q;

endmodule

// File: tb/tb_midi_note_decoder.sv
// Bench for midi_note_decoder: dut0 is CHANNEL=0/OMNI=0, dut1 is CHANNEL=0/OMNI=1, same byte stream.
module tb_midi_note_decoder;

    typedef struct {
        logic [7:0]  b;
        bit          p0;
        logic [14:0] n0;
        bit          p1;
        logic [14:0] n1;
    } vec_t;

    typedef struct {
        int          cyc;
        logic [14:0] n;
    } exp_t;

    logic clk;
    logic reset_l;
    int   n_tests;
    int   n_fail;
    int   ncyc;
    bit   prev0, prev1;
    vec_t vecs[$];
    exp_t q0[$];
    exp_t q1[$];

    midi_note_decoder_if bus0 ();
    midi_note_decoder_if bus1 ();

    midi_note_decoder #(.CHANNEL(4'd0), .OMNI(1'b0)) dut0 (
        .clock_50_000_000 (clk),
        .reset_l          (reset_l),
        .bus              (bus0)
    );

    midi_note_decoder #(.CHANNEL(4'd0), .OMNI(1'b1)) dut1 (
        .clock_50_000_000 (clk),
        .reset_l          (reset_l),
        .bus              (bus1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [14:0] nt(input bit on, input int n, input int v);
        logic [6:0] nn;
        logic [6:0] vv;
        nn = n[6:0];
        vv = v[6:0];
        return {on, nn, vv};
    endfunction

    // Byte with the same expectation for both instances.
    task automatic add(input logic [7:0] b, input bit p, input logic [14:0] n);
        vec_t v;
        v.b = b; v.p0 = p; v.n0 = n; v.p1 = p; v.n1 = n;
        vecs.push_back(v);
    endtask

    task automatic add2(input logic [7:0] b, input bit p0, input logic [14:0] n0,
                        input bit p1, input logic [14:0] n1);
        vec_t v;
        v.b = b; v.p0 = p0; v.n0 = n0; v.p1 = p1; v.n1 = n1;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [14:0] act, input logic [14:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Called at posedge+1; strobe is sampled on the next posedge, pulse seen at the negedge after.
    task automatic send(input logic [7:0] b, input bit p0, input logic [14:0] n0,
                        input bit p1, input logic [14:0] n1);
        exp_t e;
        bus0.midi_byte = b; bus0.midi_byte_ready = 1'b1;
        bus1.midi_byte = b; bus1.midi_byte_ready = 1'b1;
        e.cyc = ncyc + 2;
        if (p0) begin e.n = n0; q0.push_back(e); end
        if (p1) begin e.n = n1; q1.push_back(e); end
        @(posedge clk);
        #1;
        bus0.midi_byte_ready = 1'b0;
        bus1.midi_byte_ready = 1'b0;
    endtask

    task automatic mon_one(input int id, input logic rdy, input logic [14:0] n);
        exp_t e;
        bit   prev;
        bit   empty;
        prev  = (id == 0) ? prev0 : prev1;
        empty = (id == 0) ? (q0.size() == 0) : (q1.size() == 0);
        if (rdy && prev) begin
            n_tests++;
            n_fail++;
            $display("FAIL dut%0d note_ready_consecutive: high two cycles, expected single pulse", id);
        end
        if (rdy) begin
            n_tests++;
            if (empty) begin
                n_fail++;
                $display("FAIL dut%0d unexpected_pulse: cycle %0d note %h, expected no pulse",
                         id, ncyc, n);
            end else begin
                if (id == 0) e = q0.pop_front();
                else         e = q1.pop_front();
                if (e.cyc != ncyc || e.n !== n) begin
                    n_fail++;
                    $display("FAIL dut%0d pulse: cycle %0d note %h, expected cycle %0d note %h",
                             id, ncyc, n, e.cyc, e.n);
                end
            end
        end
        if (id == 0) prev0 = rdy;
        else         prev1 = rdy;
    endtask

    task automatic check_drained(input string name);
        n_tests++;
        if (q0.size() != 0 || q1.size() != 0) begin
            n_fail++;
            $display("FAIL %s: %0d/%0d pulses missing, expected 0/0", name, q0.size(), q1.size());
            q0.delete();
            q1.delete();
        end
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        ncyc    = 0;
        prev0   = 1'b0;
        prev1   = 1'b0;
        reset_l = 1'b0;
        bus0.midi_byte = 8'h00; bus0.midi_byte_ready = 1'b0;
        bus1.midi_byte = 8'h00; bus1.midi_byte_ready = 1'b0;

        fork
            forever begin
                @(negedge clk);
                ncyc++;
                mon_one(0, bus0.note_ready, bus0.note);
                mon_one(1, bus1.note_ready, bus1.note);
            end
        join_none

        // Basic note on
        add(8'h90, 0, 0); add(8'h0A, 0, 0); add(8'h14, 1, nt(1, 10, 20));
        // Data pair without fresh status
`ifdef MIDI_RUNNING_STATUS_EN
        add(8'h1E, 0, 0); add(8'h3C, 1, nt(1, 30, 60));
`else
        add(8'h1E, 0, 0); add(8'h3C, 0, 0);
`endif
        // Velocity-0 ON becomes OFF, then explicit OFF
        add(8'h90, 0, 0); add(8'h28, 0, 0); add(8'h00, 1, nt(0, 40, 0));
        add(8'h80, 0, 0); add(8'h14, 0, 0); add(8'h28, 1, nt(0, 20, 40));
        // Channel 1: only the OMNI instance responds
        add(8'h91, 0, 0); add(8'h0A, 0, 0); add2(8'h14, 0, 0, 1, nt(1, 10, 20));
        // Real-time byte mid-message
        add(8'h90, 0, 0); add(8'h0A, 0, 0); add(8'hF8, 0, 0); add(8'h14, 1, nt(1, 10, 20));
        // SysEx swallowed
        add(8'hF0, 0, 0); add(8'h01, 0, 0); add(8'h02, 0, 0); add(8'hF7, 0, 0); add(8'h0A, 0, 0);
        // Control change skipped
        add(8'hB0, 0, 0); add(8'h07, 0, 0); add(8'h64, 0, 0);
        add(8'h90, 0, 0); add(8'h32, 0, 0); add(8'h64, 1, nt(1, 50, 100));
        // Program change (one data byte) then a note
        add(8'hC0, 0, 0); add(8'h05, 0, 0);
        add(8'h90, 0, 0); add(8'h3C, 0, 0); add(8'h7F, 1, nt(1, 60, 127));
        // Status mid-message abandons the partial note
        add(8'h90, 0, 0); add(8'h0A, 0, 0); add(8'h80, 0, 0); add(8'h0B, 0, 0);
        add(8'h0C, 1, nt(0, 11, 12));

        #12;
        check("reset_note0", bus0.note, 15'd0);
        check("reset_note1", bus1.note, 15'd0);
        check("reset_ready0", {14'd0, bus0.note_ready}, 15'd0);
        check("reset_ready1", {14'd0, bus1.note_ready}, 15'd0);
        @(posedge clk);
        #1;
        reset_l = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < vecs.size(); i++) begin
            send(vecs[i].b, vecs[i].p0, vecs[i].n0, vecs[i].p1, vecs[i].n1);
        end
        repeat (3) @(posedge clk);
        #1;
        check_drained("table_pulses");
        check("note_hold0", bus0.note, nt(0, 11, 12));
        check("note_hold1", bus1.note, nt(0, 11, 12));

        // Bytes without the strobe are ignored
        send(8'hF0, 0, 0, 0, 0);
        bus0.midi_byte = 8'h90; bus1.midi_byte = 8'h90;
        repeat (2) @(posedge clk);
        #1;
        send(8'h0A, 0, 0, 0, 0);
        send(8'h14, 0, 0, 0, 0);
        repeat (3) @(posedge clk);
        #1;
        check_drained("no_strobe");

        // Reset mid-message
        send(8'h90, 0, 0, 0, 0);
        send(8'h0A, 0, 0, 0, 0);
        reset_l = 1'b0;
        #2;
        check("async_reset_note0", bus0.note, 15'd0);
        check("async_reset_note1", bus1.note, 15'd0);
        @(posedge clk);
        #1;
        reset_l = 1'b1;
        send(8'h14, 0, 0, 0, 0);
        repeat (3) @(posedge clk);
        #1;
        check("post_reset_note0", bus0.note, 15'd0);
        check("post_reset_note1", bus1.note, 15'd0);
        check_drained("post_reset");

        // Back-to-back after reset still decodes
        send(8'h90, 0, 0, 0, 0);
        send(8'h7F, 0, 0, 0, 0);
        send(8'h01, 1, nt(1, 127, 1), 1, nt(1, 127, 1));
        repeat (3) @(posedge clk);
        #1;
        check_drained("final");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
